// File: rtl/procesador_adc_scanner_pkg.sv
// Shared definitions for the ADC channel scanner: register map, bit positions,
// FSM encoding and the averaging limit.
package procesador_adc_scanner_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_SETTLE  = 3'd1;
  localparam logic [2:0] ADDR_AVG     = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_RESULT0 = 3'd4;
  localparam logic [2:0] ADDR_RESULT1 = 3'd5;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_IE    = 2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_CHSEL = 2;

  localparam logic [2:0] AVG_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACQ,
    ST_STORE
  } state_t;

  function automatic logic [2:0] clamp_avg(input logic [2:0] k);
    return (k > AVG_MAX) ? AVG_MAX : k;
  endfunction

endpackage

// File: rtl/procesador_adc_avg.sv
// Sums 2^k ADC samples and presents the truncated mean; last flags the
// sample that completes the set (combinational, same cycle as valid).
module procesador_adc_avg
  import procesador_adc_scanner_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        k,
  output logic [DATA_W-1:0] result,
  output logic              last
);

  localparam int CNT_W = int'(AVG_MAX);
  localparam int ACC_W = DATA_W + CNT_W;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   n_last;
  logic             unused_hi;

  assign n_last    = ((CNT_W+1)'(1) << k) - (CNT_W+1)'(1);
  assign last      = valid && ({1'b0, cnt} == n_last);
  assign shifted   = acc >> k;
  // The mean of DATA_W-bit samples always fits DATA_W bits.
  assign result    = shifted[DATA_W-1:0];
  assign unused_hi = ^shifted[ACC_W-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (valid) begin
      acc <= acc + ACC_W'(data);
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/procesador_adc_scanner.sv
// Avalon-MM slave that scans the two-way ADC mux: settle, average 2^k samples,
// store per-channel results, raise done/irq after channel 1.
module procesador_adc_scanner
  import procesador_adc_scanner_pkg::*;
#(
  parameter int          DATA_W     = 14,
  parameter logic [15:0] SETTLE_RST = 16'd16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              channel_sel,
  output logic              irq
);

  state_t            state;
  logic              wr, start_req, done_clr;
  logic              run_q, ie_q, done_q, ch_q;
  logic [15:0]       settle_q, settle_w, cnt;
  logic [2:0]        avg_q, k_w;
  logic [DATA_W-1:0] result0, result1, avg_res;
  logic              avg_clear, avg_valid, avg_last;
  logic              unused_wdata;

  assign wr           = chipselect && !write_n;
  assign start_req    = wr && (address == ADDR_CTRL) && writedata[CTRL_START];
  assign done_clr     = wr && (address == ADDR_STATUS) && writedata[STAT_DONE];
  assign unused_wdata = ^writedata[31:16];

  assign avg_clear   = (state == ST_SETTLE) && (cnt == '0);
  assign avg_valid   = adc_valid && (state == ST_ACQ);
  assign channel_sel = ch_q;
  assign irq         = done_q && ie_q;

  procesador_adc_avg #(.DATA_W(DATA_W)) u_avg (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (avg_clear),
    .valid   (avg_valid),
    .data    (adc_data),
    .k       (k_w),
    .result  (avg_res),
    .last    (avg_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      ie_q     <= 1'b0;
      settle_q <= SETTLE_RST;
      avg_q    <= '0;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          run_q <= writedata[CTRL_RUN];
          ie_q  <= writedata[CTRL_IE];
        end
        ADDR_SETTLE: settle_q <= writedata[15:0];
        ADDR_AVG:    avg_q    <= clamp_avg(writedata[2:0]);
        default: ;
      endcase
    end
  end

  // SETTLE/AVG are snapshotted at scan start so mid-scan writes wait a scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      settle_w <= '0;
      k_w      <= '0;
      ch_q     <= 1'b0;
      done_q   <= 1'b0;
      result0  <= '0;
      result1  <= '0;
    end else begin
      if (done_clr) done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          ch_q <= 1'b0;
          if (start_req || run_q) begin
            state    <= ST_SETTLE;
            cnt      <= settle_q;
            settle_w <= settle_q;
            k_w      <= avg_q;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_ACQ;
          else           cnt   <= cnt - 16'd1;
        end
        ST_ACQ: begin
          if (avg_last) state <= ST_STORE;
        end
        ST_STORE: begin
          if (!ch_q) begin
            result0 <= avg_res;
            ch_q    <= 1'b1;
            cnt     <= settle_w;
            state   <= ST_SETTLE;
          end else begin
            result1 <= avg_res;
            ch_q    <= 1'b0;
            done_q  <= 1'b1;
            if (run_q) begin
              state    <= ST_SETTLE;
              cnt      <= settle_q;
              settle_w <= settle_q;
              k_w      <= avg_q;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN] = run_q;
        readdata[CTRL_IE]  = ie_q;
      end
      ADDR_SETTLE: readdata[15:0] = settle_q;
      ADDR_AVG:    readdata[2:0]  = avg_q;
      ADDR_STATUS: begin
        readdata[STAT_BUSY]  = (state != ST_IDLE);
        readdata[STAT_DONE]  = done_q;
        readdata[STAT_CHSEL] = ch_q;
      end
      ADDR_RESULT0: readdata[DATA_W-1:0] = result0;
      ADDR_RESULT1: readdata[DATA_W-1:0] = result1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_procesador_adc_scanner.sv
// Directed bench for procesador_adc_scanner: register reset values, one-shot
// and continuous scans, sparse ADC samples, busy-time writes, irq and reset.
module tb_procesador_adc_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic        channel_sel;
  logic        irq;

  // ADC source: either follows the mux (v0/v1, always valid) or is hand-driven.
  logic        adc_manual = 1'b0;
  logic        man_valid = 1'b0;
  logic [13:0] man_data = '0;
  logic [13:0] v0 = '0;
  logic [13:0] v1 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (adc_manual) begin
      adc_data  = man_data;
      adc_valid = man_valid;
    end else begin
      adc_data  = channel_sel ? v1 : v0;
      adc_valid = 1'b1;
    end
  end

  procesador_adc_scanner #(.DATA_W(14), .SETTLE_RST(16'd16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .channel_sel (channel_sel),
    .irq         (irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Counts edges until STATUS.done reads 1, bounded at 300 cycles.
  task automatic wait_done(input int n0, output int n);
    logic [31:0] s;
    n = n0;
    do begin
      @(posedge clk); #1;
      n++;
      bus_read(3'd3, s);
    end while (!s[1] && n < 300);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(3'd0, rd); checks++; if (rd !== 32'd0)  begin errors++; $display("FAIL rst_ctrl got %0h exp 0", rd); end
    bus_read(3'd1, rd); checks++; if (rd !== 32'd16) begin errors++; $display("FAIL rst_settle got %0d exp 16", rd); end
    bus_read(3'd2, rd); checks++; if (rd !== 32'd0)  begin errors++; $display("FAIL rst_avg got %0d exp 0", rd); end
    bus_read(3'd3, rd); checks++; if (rd !== 32'd0)  begin errors++; $display("FAIL rst_status got %0h exp 0", rd); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd0)  begin errors++; $display("FAIL rst_result0 got %0d exp 0", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd0)  begin errors++; $display("FAIL rst_result1 got %0d exp 0", rd); end
    checks++; if (channel_sel !== 1'b0) begin errors++; $display("FAIL rst_chsel got %b exp 0", channel_sel); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL addr6 got %0h exp 0", rd); end
    bus_read(3'd7, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL addr7 got %0h exp 0", rd); end
  endtask

  task automatic test_one_shot;
    logic [31:0] rd;
    int n;
    adc_manual = 1'b0; v0 = 14'd100; v1 = 14'd200;
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h2);
    bus_read(3'd0, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL start_selfclear got %0h exp 0", rd); end
    wait_done(0, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL oneshot_cycles got %0d exp 12", n); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd100) begin errors++; $display("FAIL oneshot_r0 got %0d exp 100", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd200) begin errors++; $display("FAIL oneshot_r1 got %0d exp 200", rd); end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h2) begin errors++; $display("FAIL oneshot_status got %0h exp 2", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq got %b exp 0", irq); end
  endtask

  task automatic test_avg_sparse;
    logic [31:0] rd;
    bus_write(3'd3, 32'h2);
    bus_write(3'd2, 32'd2);
    adc_manual = 1'b1; man_valid = 1'b0;
    bus_write(3'd0, 32'h2);
    // Iteration j is sampled on edge start+1+j; ch0 ACQ opens after edge start+4.
    for (int j = 0; j < 40; j++) begin
      man_valid = (j % 3 == 0);
      case (j)
        0:  man_data = 14'd500;
        3:  man_data = 14'd900;
        6:  man_data = 14'd10;
        9:  man_data = 14'd11;
        12: man_data = 14'd12;
        15: man_data = 14'd13;
        default: man_data = 14'd40;
      endcase
      @(posedge clk); #1;
    end
    man_valid = 1'b0;
    bus_read(3'd4, rd); checks++; if (rd !== 32'd11) begin errors++; $display("FAIL sparse_r0 got %0d exp 11", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd40) begin errors++; $display("FAIL sparse_r1 got %0d exp 40", rd); end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h2) begin errors++; $display("FAIL sparse_status got %0h exp 2", rd); end
  endtask

  task automatic test_run_stop;
    logic [31:0] rd;
    int n, busy_cnt;
    adc_manual = 1'b0; v0 = 14'd7; v1 = 14'd9;
    bus_write(3'd3, 32'h2);
    bus_write(3'd2, 32'd0);
    bus_read(3'd3, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL done_clear got %0h exp 0", rd); end
    bus_write(3'd0, 32'h1);
    repeat (3) begin @(posedge clk); #1; end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h1) begin errors++; $display("FAIL run_busy got %0h exp 1", rd); end
    bus_write(3'd0, 32'h0);
    wait_done(0, n);
    bus_read(3'd4, rd); checks++; if (rd !== 32'd7) begin errors++; $display("FAIL run_r0 got %0d exp 7", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd9) begin errors++; $display("FAIL run_r1 got %0d exp 9", rd); end
    v0 = 14'd55;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus_read(3'd3, rd);
      if (rd[0]) busy_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL run_rescan busy_cycles got %0d exp 0", busy_cnt); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd7) begin errors++; $display("FAIL run_r0_held got %0d exp 7", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    int n;
    v0 = 14'd20; v1 = 14'd30;
    bus_write(3'd3, 32'h2);
    bus_write(3'd0, 32'h2);
    bus_write(3'd0, 32'h2);
    bus_write(3'd2, 32'd7);
    bus_read(3'd2, rd); checks++; if (rd !== 32'd4) begin errors++; $display("FAIL avg_clamp got %0d exp 4", rd); end
    wait_done(2, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL busy_start_cycles got %0d exp 12", n); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd20) begin errors++; $display("FAIL busy_r0 got %0d exp 20", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd30) begin errors++; $display("FAIL busy_r1 got %0d exp 30", rd); end
    v0 = 14'd21; v1 = 14'd31;
    bus_write(3'd3, 32'h2);
    bus_write(3'd0, 32'h2);
    wait_done(0, n);
    checks++; if (n !== 42) begin errors++; $display("FAIL k4_cycles got %0d exp 42", n); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd21) begin errors++; $display("FAIL k4_r0 got %0d exp 21", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd31) begin errors++; $display("FAIL k4_r1 got %0d exp 31", rd); end
  endtask

  task automatic test_irq_reset;
    logic [31:0] rd;
    bus_write(3'd0, 32'h4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    bus_write(3'd3, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_status got %0h exp 0", rd); end
    bus_write(3'd0, 32'h6);
    repeat (8) begin @(posedge clk); #1; end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h1) begin errors++; $display("FAIL acq_busy got %0h exp 1", rd); end
    reset_n = 1'b0;
    #2;
    checks++; if (channel_sel !== 1'b0) begin errors++; $display("FAIL midrst_chsel got %b exp 0", channel_sel); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp 0", irq); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_read(3'd3, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_status got %0h exp 0", rd); end
    bus_read(3'd4, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_r0 got %0d exp 0", rd); end
    bus_read(3'd5, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_r1 got %0d exp 0", rd); end
    bus_read(3'd1, rd); checks++; if (rd !== 32'd16) begin errors++; $display("FAIL midrst_settle got %0d exp 16", rd); end
    bus_read(3'd2, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_avg got %0d exp 0", rd); end
    bus_read(3'd0, rd); checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_ctrl got %0h exp 0", rd); end
    repeat (5) begin @(posedge clk); #1; end
    bus_read(3'd3, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_idle got %0h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_avg_sparse();
    test_run_stop();
    test_back_to_back();
    test_irq_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
